serial_addsub: RTL and testbench
================================

Name: serial_addsub

Overview:
- Parametrised bit-serial adder/subtractor. Successor to the team's fixed 8-bit serial adder.
- Adds:
  - generic operand width
  - configurable digit size (bits processed per cycle)
  - subtract mode
  - carry-out and signed-overflow flags
  - busy/done handshake
- Used as a low-area arithmetic unit behind a MicroBlaze custom-instruction/FSL wrapper.

Parameters:
- WIDTH, 8: operand and result width in bits. Must be ≥ 2.
- DIGIT, 1: bits processed per clock. WIDTH must be an integer multiple of DIGIT; elaboration error otherwise.

Ports:
- clk  in  1  system clock, rising edge active
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- sub  in  1  0 = a+b, 1 = a−b; latched with operands
- a  in  WIDTH  operand A; latched at accepted start
- b  in  WIDTH  operand B; latched at accepted start
- c  out  WIDTH  result; valid from done, held until next accepted start
- cout  out  1  carry out of MSB (for sub: 1 = no borrow)
- ovf  out  1  two's-complement signed overflow
- busy  out  1  high from accepted start until done cycle inclusive
- done  out  1  one-cycle pulse, result valid

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high (rst).
- Reset values: state = IDLE; c, cout, ovf, busy, done = 0; internal shift registers, carry and digit counter = 0.
- N = WIDTH/DIGIT digit steps.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1 at edge E0: latch A←a, B←(sub ? ~b : b), carry←sub, cnt←0.
  - Go to RUN; busy=1 from E0.
  - start=0 keeps IDLE.
- RUN, at each edge Ei (i = 1..N):
  - Add DIGIT LSBs of A, B and carry.
  - Shift A and B right by DIGIT.
  - Shift the sum digit into c from the top, so after N shifts the LSB digit sits at c[DIGIT−1:0].
  - Update carry; cnt++.
  - At EN (cnt = N−1 before the edge): register cout = final carry and ovf = (A_msb == B_msb) && (sum_msb != A_msb), using the MSB digit's operand bits. Go to DONE.
- DONE:
  - done=1 and busy=1 for exactly one cycle (EN to EN+1).
  - At EN+1: go to IDLE; done=0, busy=0.
- Latency:
  - start sampled at E0 → done high after EN.
  - N+1 cycles per operation, including the DONE cycle.
  - Minimum start-to-start spacing is N+2 cycles.
- c register:
  - Shifts during RUN, so intermediate values are not meaningful while busy=1 and done=0.
  - Holds the final value in DONE and IDLE until the next accepted start.
- cout and ovf are held from EN until the next accepted start, which clears both to 0.
- Ignored inputs:
  - start while in RUN or DONE is ignored.
  - Changes on a, b, sub after acceptance do not affect the operation in flight.
- rst asserted at any time, including mid-RUN: immediate return to reset values. No done pulse for the aborted operation.
- Arithmetic is modulo 2^WIDTH. No saturation.

Decomposition:
- Package serial_addsub_pkg:
  - state encoding constants (IDLE, RUN, DONE)
  - function clog2 for counter width (max(1, clog2(N)))
- Sub-module serial_addsub_digit:
  - combinational DIGIT-bit ripple adder
  - inputs: x[DIGIT], y[DIGIT], ci
  - outputs: s[DIGIT], co, and carry into MSB (for ovf cross-check)
- Top module holds the FSM, counter, operand shift registers, result register and flags.

Test Plan:
1. WIDTH=8, DIGIT=1, a=0xB7, b=0xB9, sub=0, start pulse → done after exactly 8 cycles; c=0x70, cout=1, ovf=1; busy high 9 cycles.
2. WIDTH=8, DIGIT=1, a=0x05, b=0x07, sub=1 → c=0xFE, cout=0 (borrow), ovf=0. Then a=0x80, b=0x01, sub=1 → c=0x7F, cout=1, ovf=1.
3. WIDTH=16, DIGIT=4, a=0x7FFF, b=0x0001, sub=0 → done at E4; c=0x8000, cout=0, ovf=1.
4. WIDTH=8, DIGIT=1: start, then change a/b and pulse start again at E3 → second start ignored; result matches the original operands; exactly one done pulse.
5. Assert rst for one cycle at E4 of an operation → busy=0, done never pulses, c=0, cout=0, ovf=0. New start afterwards gives a correct result (0xB7+0xB9 → 0x70).
6. Back-to-back: start held high continuously for three operations → accepted only in IDLE; done pulses spaced N+2 cycles apart; each c correct.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding and
// the counter-width helper.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = 32'sd1;
    while ((32'sd1 << w) < n) begin
      w = w + 32'sd1;
    end
    return w;
  endfunction

endpackage : serial_addsub_pkg

// File: rtl/serial_addsub_if.sv
// Request/result bundle of the serial adder/subtractor. The requester owns
// start/sub/a/b; the arithmetic unit owns the result, flags and handshake.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output start, sub, a, b,
    input  c, cout, ovf, busy, done
  );

  modport slave (
    input  start, sub, a, b,
    output c, cout, ovf, busy, done
  );
endinterface : serial_addsub_if

// File: rtl/serial_addsub_digit.sv
// Combinational DIGIT-bit ripple adder. Besides the carry out it exposes the
// carry into the most significant bit, so the caller can derive signed
// overflow as the XOR of the two top carries.
module serial_addsub_digit
  import serial_addsub_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             cm
);

  logic [DIGIT:0] carry_s;

  // Ripple the carry through the digit, LSB first.
  always_comb begin
    carry_s    = '0;
    s          = '0;
    carry_s[0] = ci;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]         = x[i] ^ y[i] ^ carry_s[i];
      carry_s[i+1] = (x[i] & y[i]) | (x[i] & carry_s[i]) | (y[i] & carry_s[i]);
    end
    co = carry_s[DIGIT];
    cm = carry_s[DIGIT-1];
  end

endmodule : serial_addsub_digit

// File: rtl/serial_addsub.sv
// Parametrised bit-serial adder/subtractor. Operands are latched on an
// accepted start, then consumed DIGIT bits per clock, LSB digit first; the
// result is shifted into c from the top so it lands right-aligned after the
// last digit. Subtraction is a + ~b + 1, the +1 entering as the initial carry.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic           clk,
  input  logic           rst,
  serial_addsub_if.slave bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  generate
    if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
      $error("serial_addsub: WIDTH must be >= 2 and an integer multiple of DIGIT");
    end
  endgenerate

  state_e               state_r, state_nxt_s;
  logic [WIDTH-1:0]     a_r, a_nxt_s;
  logic [WIDTH-1:0]     b_r, b_nxt_s;
  logic [WIDTH-1:0]     c_r, c_nxt_s;
  logic                 carry_r, carry_nxt_s;
  logic [CW-1:0]        cnt_r, cnt_nxt_s;
  logic                 cout_r, cout_nxt_s;
  logic                 ovf_r, ovf_nxt_s;
  logic                 busy_r, busy_nxt_s;
  logic                 done_r, done_nxt_s;

  logic [DIGIT-1:0]     sum_s;
  logic                 co_s;
  logic                 cm_s;
  logic [WIDTH+DIGIT-1:0] cat_s;

  serial_addsub_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .x  (a_r[DIGIT-1:0]),
    .y  (b_r[DIGIT-1:0]),
    .ci (carry_r),
    .s  (sum_s),
    .co (co_s),
    .cm (cm_s)
  );

  // New sum digit enters at the top of the result; the rest moves down.
  assign cat_s = {sum_s, c_r};

  // Next-state and datapath update for IDLE -> RUN (N digits) -> DONE -> IDLE.
  always_comb begin
    state_nxt_s = state_r;
    a_nxt_s     = a_r;
    b_nxt_s     = b_r;
    c_nxt_s     = c_r;
    carry_nxt_s = carry_r;
    cnt_nxt_s   = cnt_r;
    cout_nxt_s  = cout_r;
    ovf_nxt_s   = ovf_r;
    busy_nxt_s  = busy_r;
    done_nxt_s  = done_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          a_nxt_s     = bus.a;
          b_nxt_s     = bus.sub ? ~bus.b : bus.b;
          carry_nxt_s = bus.sub;
          cnt_nxt_s   = '0;
          cout_nxt_s  = 1'b0;
          ovf_nxt_s   = 1'b0;
          busy_nxt_s  = 1'b1;
          done_nxt_s  = 1'b0;
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        a_nxt_s     = a_r >> DIGIT;
        b_nxt_s     = b_r >> DIGIT;
        c_nxt_s     = cat_s[WIDTH+DIGIT-1:DIGIT];
        carry_nxt_s = co_s;
        cnt_nxt_s   = cnt_r + CW'(1'b1);
        if (cnt_r == CNT_LAST) begin
          // Sign-rule overflow (equal operand signs, different sum sign)
          // equals the XOR of the carries into and out of the MSB.
          cout_nxt_s  = co_s;
          ovf_nxt_s   = co_s ^ cm_s;
          done_nxt_s  = 1'b1;
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        done_nxt_s  = 1'b0;
        busy_nxt_s  = 1'b0;
        state_nxt_s = IDLE;
      end
      default: begin
        done_nxt_s  = 1'b0;
        busy_nxt_s  = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, datapath and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      c_r     <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      a_r     <= a_nxt_s;
      b_r     <= b_nxt_s;
      c_r     <= c_nxt_s;
      carry_r <= carry_nxt_s;
      cnt_r   <= cnt_nxt_s;
      cout_r  <= cout_nxt_s;
      ovf_r   <= ovf_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  assign bus.c    = c_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule : serial_addsub

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: an 8-bit/1-bit-digit and a 16-bit/4-bit-digit
// instance, a table of directed vectors, randomized operations against an
// arithmetic reference model, and hand-written multi-cycle sequences.
module tb_serial_addsub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cur_sel = 0;

  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(8))  if8 ();
  serial_addsub_if #(.WIDTH(16)) if16 ();

  serial_addsub #(.WIDTH(8),  .DIGIT(1)) dut8  (.clk(clk), .rst(rst), .bus(if8));
  serial_addsub #(.WIDTH(16), .DIGIT(4)) dut16 (.clk(clk), .rst(rst), .bus(if16));

  logic [31:0] mc;
  logic        mcout, movf, mbusy, mdone;

  // Present the selected instance's outputs on common monitor signals.
  always_comb begin
    if (cur_sel != 0) begin
      mc = {16'd0, if16.c}; mcout = if16.cout; movf = if16.ovf;
      mbusy = if16.busy; mdone = if16.done;
    end else begin
      mc = {24'd0, if8.c}; mcout = if8.cout; movf = if8.ovf;
      mbusy = if8.busy; mdone = if8.done;
    end
  end

  typedef struct {
    int          sel;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] exp_c;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic drive(input int sel, input logic st, input logic [31:0] a,
                       input logic [31:0] b, input logic sub);
    if (sel != 0) begin
      if16.start = st; if16.a = a[15:0]; if16.b = b[15:0]; if16.sub = sub;
    end else begin
      if8.start = st; if8.a = a[7:0]; if8.b = b[7:0]; if8.sub = sub;
    end
  endtask

  // Reference: plain modular and signed arithmetic on the operand values.
  function automatic void model_op(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic sub, output logic [31:0] c,
                                   output logic cout, output logic ovf);
    longint m, half, ua, ub, sa, sb, r, sr;
    m    = longint'(1) << w;
    half = m / 2;
    ua   = longint'(a) % m;
    ub   = longint'(b) % m;
    sa   = (ua >= half) ? ua - m : ua;
    sb   = (ub >= half) ? ub - m : ub;
    if (sub) begin
      r    = ua - ub;
      cout = (ua >= ub);
      if (r < 0) r = r + m;
      sr   = sa - sb;
    end else begin
      r    = ua + ub;
      cout = (r >= m);
      r    = r % m;
      sr   = sa + sb;
    end
    c   = 32'(r);
    ovf = (sr >= half) || (sr < -half);
  endfunction

  // One complete operation with latency, busy-length and result checks.
  task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [31:0] exp_c,
                        input logic exp_cout, input logic exp_ovf);
    int n, lat, busy_cnt;
    n = (sel != 0) ? 4 : 8;
    cur_sel = sel;
    @(negedge clk);
    drive(sel, 1'b1, a, b, sub);
    @(posedge clk); #1;
    drive(sel, 1'b0, ~a, ~b, ~sub);
    chk("busy_at_accept", {31'd0, mbusy}, 32'd1);
    busy_cnt = 1;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (mbusy) busy_cnt++;
      if (mdone) begin
        lat = k;
        break;
      end
    end
    chk("latency", lat, n);
    chk("c", mc, exp_c);
    chk("cout", {31'd0, mcout}, {31'd0, exp_cout});
    chk("ovf", {31'd0, movf}, {31'd0, exp_ovf});
    chk("busy_cycles", busy_cnt, n + 1);
    @(posedge clk); #1;
    chk("done_cleared", {31'd0, mdone}, 32'd0);
    chk("busy_cleared", {31'd0, mbusy}, 32'd0);
    chk("c_held", mc, exp_c);
  endtask

  initial begin
    logic [31:0] ec, ra, rb, mask;
    logic        ecout, eovf, rsub;
    int          rsel, dcount, dcyc;
    int          done_at[3];
    logic [31:0] ba[3];
    logic [31:0] bb[3];
    logic        bs[3];

    tbl[0] = '{0, 32'hB7,   32'hB9,   1'b0, 32'h70,   1'b1, 1'b1};
    tbl[1] = '{0, 32'h05,   32'h07,   1'b1, 32'hFE,   1'b0, 1'b0};
    tbl[2] = '{0, 32'h80,   32'h01,   1'b1, 32'h7F,   1'b1, 1'b1};
    tbl[3] = '{1, 32'h7FFF, 32'h0001, 1'b0, 32'h8000, 1'b0, 1'b1};
    tbl[4] = '{0, 32'h00,   32'h00,   1'b1, 32'h00,   1'b1, 1'b0};
    tbl[5] = '{1, 32'hFFFF, 32'h0001, 1'b0, 32'h0000, 1'b1, 1'b0};
    tbl[6] = '{1, 32'h8000, 32'h0001, 1'b1, 32'h7FFF, 1'b1, 1'b1};

    drive(0, 1'b0, 32'd0, 32'd0, 1'b0);
    drive(1, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state of both instances.
    for (int s = 0; s < 2; s++) begin
      cur_sel = s;
      #1;
      chk("rst_c", mc, 32'd0);
      chk("rst_cout", {31'd0, mcout}, 32'd0);
      chk("rst_ovf", {31'd0, movf}, 32'd0);
      chk("rst_busy", {31'd0, mbusy}, 32'd0);
      chk("rst_done", {31'd0, mdone}, 32'd0);
    end

    // Directed vectors.
    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].sub,
             tbl[i].exp_c, tbl[i].exp_cout, tbl[i].exp_ovf);
    end

    // Randomized operations against the model.
    for (int i = 0; i < 30; i++) begin
      rsel = int'($urandom_range(1, 0));
      mask = (rsel != 0) ? 32'hFFFF : 32'hFF;
      ra   = $urandom & mask;
      rb   = $urandom & mask;
      rsub = 1'($urandom_range(1, 0));
      model_op((rsel != 0) ? 16 : 8, ra, rb, rsub, ec, ecout, eovf);
      run_op(rsel, ra, rb, rsub, ec, ecout, eovf);
    end

    // Second start at E3 with new operands is ignored.
    cur_sel = 0;
    @(negedge clk);
    drive(0, 1'b1, 32'h12, 32'h34, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 32'h12, 32'h34, 1'b0);
    dcount = 0; dcyc = 0; ec = 32'd0; ecout = 1'b0; eovf = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 3) drive(0, 1'b1, 32'hFF, 32'hFF, 1'b1);
      else        drive(0, 1'b0, 32'hFF, 32'hFF, 1'b1);
      @(posedge clk); #1;
      if (mdone) begin
        dcount++; dcyc = k; ec = mc; ecout = mcout; eovf = movf;
      end
    end
    chk("ign_done_count", dcount, 1);
    chk("ign_done_cycle", dcyc, 8);
    chk("ign_c", ec, 32'h46);
    chk("ign_cout", {31'd0, ecout}, 32'd0);
    chk("ign_ovf", {31'd0, eovf}, 32'd0);

    // Reset in the middle of an operation.
    @(negedge clk);
    drive(0, 1'b1, 32'hB7, 32'hB9, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 32'hB7, 32'hB9, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, mbusy}, 32'd0);
    chk("abort_done", {31'd0, mdone}, 32'd0);
    chk("abort_c", mc, 32'd0);
    chk("abort_cout", {31'd0, mcout}, 32'd0);
    chk("abort_ovf", {31'd0, movf}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (mdone) dcount++;
    end
    chk("abort_no_done", dcount, 0);
    run_op(0, 32'hB7, 32'hB9, 1'b0, 32'h70, 1'b1, 1'b1);

    // Start held high across three back-to-back operations.
    ba[0] = 32'h12; bb[0] = 32'h34; bs[0] = 1'b0;
    ba[1] = 32'hF0; bb[1] = 32'h20; bs[1] = 1'b1;
    ba[2] = 32'h80; bb[2] = 32'h80; bs[2] = 1'b0;
    cur_sel = 0;
    dcount = 0;
    done_at[0] = 0; done_at[1] = 0; done_at[2] = 0;
    @(negedge clk);
    drive(0, 1'b1, ba[0], bb[0], bs[0]);
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(posedge clk); #1;
      if (mdone) begin
        done_at[dcount] = cyc;
        model_op(8, ba[dcount], bb[dcount], bs[dcount], ec, ecout, eovf);
        chk("b2b_c", mc, ec);
        chk("b2b_cout", {31'd0, mcout}, {31'd0, ecout});
        chk("b2b_ovf", {31'd0, movf}, {31'd0, eovf});
        dcount++;
        @(negedge clk);
        if (dcount < 3) drive(0, 1'b1, ba[dcount], bb[dcount], bs[dcount]);
        else            drive(0, 1'b0, 32'd0, 32'd0, 1'b0);
      end
      if (dcount == 3) break;
    end
    chk("b2b_count", dcount, 3);
    chk("b2b_first", done_at[0], 9);
    chk("b2b_gap1", done_at[1] - done_at[0], 10);
    chk("b2b_gap2", done_at[2] - done_at[1], 10);
    repeat (2) @(posedge clk);
    #1;
    chk("b2b_idle", {31'd0, mbusy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_serial_addsub
